bus_result_monitor: RTL and testbench

- Bus-snooping checker between the CPU memory bus (address, write data, write enable into `mem`) and a directed-test bench.
- Watches CPU writes to a configured result address and a done address, and enforces a cycle timeout.
- Reports a sticky pass/fail verdict, replacing fixed-delay waits followed by RAM peeks.
- Synthesizable; usable in simulation and in an FPGA test harness.

---
 rtl/bus_result_monitor.sv | 140 ++++++++++++++
 tb/tb_bus_result_monitor.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_result_monitor.sv
// bus_result_monitor: snoops CPU writes to a result address and a done address,
// enforces a run timeout and holds a sticky pass/fail verdict for a directed test.
module bus_result_monitor #(
  parameter logic [15:0] RESULT_ADDR    = 16'h0071,
  parameter logic [15:0] DONE_ADDR      = 16'h0072,
  parameter logic [7:0]  EXPECT         = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 140
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mem_adr,
  input  logic [7:0]  mem_data,
  input  logic        mem_we,
  output logic        done,
  output logic        pass,
  output logic        timed_out,
  output logic [7:0]  result_val,
  output logic        result_seen,
  output logic [7:0]  wr_count,
  output logic [15:0] cycle_count
);

  // Value cycle_count holds during the last RUN cycle before a forced finish.
  localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timed_out_q, timed_out_d;
  logic [7:0]  result_val_q, result_val_d;
  logic        result_seen_q, result_seen_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  logic       hit_r;
  logic       hit_d;
  logic       to_hit;
  logic       finish;
  logic       seen_next;
  logic [7:0] val_next;
  logic       pass_cond;

  // Bus decode and the post-update view the verdict is judged on, so a result
  // write landing on the finishing cycle still counts.
  always_comb begin
    hit_r     = mem_we & (mem_adr == RESULT_ADDR);
    hit_d     = mem_we & (mem_adr == DONE_ADDR);
    to_hit    = (cycle_count_q == LAST_CYCLE) & ~hit_d;
    finish    = hit_d | to_hit;
    seen_next = result_seen_q | hit_r;
    val_next  = hit_r ? mem_data : result_val_q;
    pass_cond = seen_next & (val_next == EXPECT);
  end

  // Next-state and counter logic; start wins over everything except reset and
  // discards any bus hit in the same cycle.
  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timed_out_d   = timed_out_q;
    result_val_d  = result_val_q;
    result_seen_d = result_seen_q;
    wr_count_d    = wr_count_q;
    cycle_count_d = cycle_count_q;

    if (start) begin
      state_d       = ST_RUN;
      done_d        = 1'b0;
      pass_d        = 1'b0;
      timed_out_d   = 1'b0;
      result_val_d  = 8'h00;
      result_seen_d = 1'b0;
      wr_count_d    = 8'h00;
      cycle_count_d = 16'h0000;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cycle_count_q != 16'hFFFF) begin
            cycle_count_d = cycle_count_q + 16'd1;
          end
          if (hit_r) begin
            result_val_d  = mem_data;
            result_seen_d = 1'b1;
            if (wr_count_q != 8'hFF) begin
              wr_count_d = wr_count_q + 8'd1;
            end
          end
          if (finish) begin
            state_d     = pass_cond ? ST_PASS : ST_FAIL;
            done_d      = 1'b1;
            pass_d      = pass_cond;
            timed_out_d = to_hit;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      result_val_q  <= 8'h00;
      result_seen_q <= 1'b0;
      wr_count_q    <= 8'h00;
      cycle_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timed_out_q   <= timed_out_d;
      result_val_q  <= result_val_d;
      result_seen_q <= result_seen_d;
      wr_count_q    <= wr_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign result_val  = result_val_q;
  assign result_seen = result_seen_q;
  assign wr_count    = wr_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_bus_result_monitor.sv
// Testbench for bus_result_monitor: three instances (default, result==done
// address, long timeout) share one bus and are compared against a run-level model.
module tb_bus_result_monitor;

  logic        ph2;
  logic        reset;
  logic        start;
  logic [15:0] mem_adr;
  logic [7:0]  mem_data;
  logic        mem_we;

  logic [2:0]  doneV, passV, toV, seenV;
  logic [7:0]  valV [3];
  logic [7:0]  wrV  [3];
  logic [15:0] cycV [3];

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model of each instance: one record per run.
  logic       mRun  [3];
  logic       mDone [3];
  logic       mPass [3];
  logic       mTo   [3];
  logic       mSeen [3];
  logic [7:0] mVal  [3];
  int         mWr   [3];
  int         mCyc  [3];

  bus_result_monitor u_def (
    .ph2(ph2), .reset(reset), .start(start), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_we(mem_we), .done(doneV[0]), .pass(passV[0]), .timed_out(toV[0]),
    .result_val(valV[0]), .result_seen(seenV[0]), .wr_count(wrV[0]), .cycle_count(cycV[0])
  );

  bus_result_monitor #(.RESULT_ADDR(16'h0071), .DONE_ADDR(16'h0071)) u_same (
    .ph2(ph2), .reset(reset), .start(start), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_we(mem_we), .done(doneV[1]), .pass(passV[1]), .timed_out(toV[1]),
    .result_val(valV[1]), .result_seen(seenV[1]), .wr_count(wrV[1]), .cycle_count(cycV[1])
  );

  bus_result_monitor #(.TIMEOUT_CYCLES(1000)) u_long (
    .ph2(ph2), .reset(reset), .start(start), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_we(mem_we), .done(doneV[2]), .pass(passV[2]), .timed_out(toV[2]),
    .result_val(valV[2]), .result_seen(seenV[2]), .wr_count(wrV[2]), .cycle_count(cycV[2])
  );

  // Free-running clock.
  initial begin
    ph2 = 1'b0;
    forever #5 ph2 = ~ph2;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] resAddr(int i);
    return 16'h0071;
  endfunction

  function automatic logic [15:0] doneAddr(int i);
    return (i == 1) ? 16'h0071 : 16'h0072;
  endfunction

  function automatic int timeoutOf(int i);
    return (i == 2) ? 1000 : 140;
  endfunction

  function automatic logic [35:0] packExp(logic d, logic p, logic t, logic s,
                                          logic [7:0] v, logic [7:0] w, logic [15:0] c);
    return {d, p, t, s, v, w, c};
  endfunction

  function automatic logic [35:0] obs(int i);
    return {doneV[i], passV[i], toV[i], seenV[i], valV[i], wrV[i], cycV[i]};
  endfunction

  function automatic logic [35:0] expOf(int i);
    return packExp(mDone[i], mPass[i], mTo[i], mSeen[i], mVal[i], 8'(mWr[i]), 16'(mCyc[i]));
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic stepModel();
    logic hitR, hitD, toNow;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mRun[i] = 0; mDone[i] = 0; mPass[i] = 0; mTo[i] = 0;
        mSeen[i] = 0; mVal[i] = 0; mWr[i] = 0; mCyc[i] = 0;
      end else if (start) begin
        mRun[i] = 1; mDone[i] = 0; mPass[i] = 0; mTo[i] = 0;
        mSeen[i] = 0; mVal[i] = 0; mWr[i] = 0; mCyc[i] = 0;
      end else if (mRun[i]) begin
        hitR  = mem_we && (mem_adr == resAddr(i));
        hitD  = mem_we && (mem_adr == doneAddr(i));
        toNow = (mCyc[i] == timeoutOf(i) - 1) && !hitD;
        mCyc[i] = (mCyc[i] >= 65535) ? 65535 : mCyc[i] + 1;
        if (hitR) begin
          mVal[i]  = mem_data;
          mSeen[i] = 1;
          mWr[i]   = (mWr[i] >= 255) ? 255 : mWr[i] + 1;
        end
        if (hitD || toNow) begin
          mRun[i]  = 0;
          mDone[i] = 1;
          mPass[i] = mSeen[i] && (mVal[i] == 8'hFF);
          mTo[i]   = toNow;
        end
      end
    end
  endtask

  // Drive one bus cycle, then sample just after the edge that consumes it.
  task automatic applyStimulus(input logic s, input logic we,
                               input logic [15:0] a, input logic [7:0] d);
    start    = s;
    mem_we   = we;
    mem_adr  = a;
    mem_data = d;
    stepModel();
    @(posedge ph2);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (obs(i) !== 36'h0) begin
        nFail++;
        $display("[TB] FAIL reset_init inst%0d: got %h want %h", i, obs(i), 36'h0);
      end
    end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (obs(i) !== 36'h0) begin
        nFail++;
        $display("[TB] FAIL reset_midrun inst%0d: got %h want %h", i, obs(i), 36'h0);
      end
    end
    applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    applyStimulus(1'b0, 1'b1, 16'h0072, 8'h00);
    nChecks++;
    if (obs(0) !== 36'h0) begin
      nFail++;
      $display("[TB] FAIL idle_ignores_bus: got %h want %h", obs(0), 36'h0);
    end
  endtask

  task automatic test_pass_on_done();
    logic [35:0] want;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) begin
        nChecks++;
        if (doneV[0] !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL done_latency: got done=%b want 0", doneV[0]);
        end
      end
      case (c)
        2:  applyStimulus(1'b0, 1'b1, 16'h0071, 8'h01);
        5:  applyStimulus(1'b0, 1'b1, 16'h0071, 8'h00);
        9:  applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
        12: applyStimulus(1'b0, 1'b1, 16'h0072, 8'h00);
        default: applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      endcase
    end
    want = packExp(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd3, 16'd13);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL pass_on_done: got %h want %h", obs(0), want);
    end
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (obs(i) !== expOf(i)) begin
        nFail++;
        $display("[TB] FAIL pass_on_done_model inst%0d: got %h want %h", i, obs(i), expOf(i));
      end
    end
  endtask

  task automatic test_timeout_fail();
    logic [35:0] want;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c < 140; c++) begin
      if (c == 139) begin
        want = packExp(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 8'd1, 16'd139);
        nChecks++;
        if (obs(0) !== want) begin
          nFail++;
          $display("[TB] FAIL before_timeout: got %h want %h", obs(0), want);
        end
      end
      if (c == 3) applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFE);
      else        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    end
    want = packExp(1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 8'd1, 16'd140);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL timeout_fail: got %h want %h", obs(0), want);
    end
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (obs(i) !== expOf(i)) begin
        nFail++;
        $display("[TB] FAIL timeout_fail_model inst%0d: got %h want %h", i, obs(i), expOf(i));
      end
    end
  endtask

  task automatic test_no_write_restart();
    logic [35:0] want;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c < 140; c++) applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    want = packExp(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 16'd140);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL no_write_timeout: got %h want %h", obs(0), want);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    nChecks++;
    if (obs(0) !== 36'h0) begin
      nFail++;
      $display("[TB] FAIL restart_clears: got %h want %h", obs(0), 36'h0);
    end
    applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    applyStimulus(1'b0, 1'b1, 16'h0072, 8'h00);
    want = packExp(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd1, 16'd2);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL restart_pass: got %h want %h", obs(0), want);
    end
  endtask

  task automatic test_timeout_edge();
    logic [35:0] want;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c < 139; c++) applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    want = packExp(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'd1, 16'd140);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL timeout_edge_pass: got %h want %h", obs(0), want);
    end
    want = packExp(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd1, 16'd140);
    nChecks++;
    if (obs(1) !== want) begin
      nFail++;
      $display("[TB] FAIL timeout_edge_done_wins: got %h want %h", obs(1), want);
    end
  endtask

  task automatic test_same_addr();
    logic [35:0] want;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    want = packExp(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd1, 16'd1);
    nChecks++;
    if (obs(1) !== want) begin
      nFail++;
      $display("[TB] FAIL same_addr_pass: got %h want %h", obs(1), want);
    end
    want = packExp(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd1, 16'd1);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL same_addr_default_running: got %h want %h", obs(0), want);
    end
  endtask

  task automatic test_start_with_hit();
    logic [35:0] want;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b0, 1'b1, 16'h0071, 8'hFF);
    applyStimulus(1'b1, 1'b1, 16'h0071, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (obs(i) !== 36'h0) begin
        nFail++;
        $display("[TB] FAIL start_discards_hit inst%0d: got %h want %h", i, obs(i), 36'h0);
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    want = packExp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 16'd1);
    nChecks++;
    if (obs(0) !== want) begin
      nFail++;
      $display("[TB] FAIL restart_keeps_running: got %h want %h", obs(0), want);
    end
  endtask

  task automatic test_noise_and_saturation();
    logic [35:0] want;
    logic [7:0]  lastData;
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 0; c < 300; c++) begin
      if (c % 2 == 0) applyStimulus(1'b0, 1'b1, 16'h0170, 8'($urandom));
      else            applyStimulus(1'b0, 1'b0, 16'h0071, 8'($urandom));
    end
    want = packExp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 16'd300);
    nChecks++;
    if (obs(2) !== want) begin
      nFail++;
      $display("[TB] FAIL noise_ignored: got %h want %h", obs(2), want);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    lastData = 8'h00;
    for (int c = 0; c < 256; c++) begin
      lastData = 8'($urandom);
      applyStimulus(1'b0, 1'b1, 16'h0071, lastData);
    end
    want = packExp(1'b0, 1'b0, 1'b0, 1'b1, lastData, 8'd255, 16'd256);
    nChecks++;
    if (obs(2) !== want) begin
      nFail++;
      $display("[TB] FAIL wr_count_saturates: got %h want %h", obs(2), want);
    end
  endtask

  task automatic test_random();
    logic       s, we;
    logic [15:0] a;
    logic [7:0]  d;
    int          sel;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      s     = ($urandom_range(0, 39) == 0);
      we    = $urandom_range(0, 1) == 1;
      sel   = $urandom_range(0, 15);
      if (sel < 6)       a = 16'h0071;
      else if (sel < 7)  a = 16'h0072;
      else if (sel < 11) a = 16'h0170;
      else               a = 16'($urandom);
      d = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      applyStimulus(s, we, a, d);
      for (int i = 0; i < 3; i++) begin
        nChecks++;
        if (obs(i) !== expOf(i)) begin
          nFail++;
          $display("[TB] FAIL random_c%0d inst%0d: got %h want %h", c, i, obs(i), expOf(i));
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    mem_we   = 1'b0;
    mem_adr  = 16'h0000;
    mem_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mRun[i] = 0; mDone[i] = 0; mPass[i] = 0; mTo[i] = 0;
      mSeen[i] = 0; mVal[i] = 0; mWr[i] = 0; mCyc[i] = 0;
    end
    @(posedge ph2);
    #1;
    test_reset();
    test_pass_on_done();
    test_timeout_fail();
    test_no_write_restart();
    test_timeout_edge();
    test_same_addr();
    test_start_with_hit();
    test_noise_and_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
